pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central handshake and valid-bit controller for the five-stage pipeline (IF, ID, EXE, MEM, WB).
- Owns one valid bit per stage. Derives per-stage allowin and register-load enables from the stage ready_go inputs.
- Squashes wrong-path instructions on a taken branch and flushes the whole pipe on a WB exception or ertn.
- The stage pipeline registers, including the EXE/MEM register, capture only when their `*_load` from this block is high. This replaces ad-hoc flush and hold logic inside the registers.

Parameters:
- CNT_W, 32, width of the retire and bubble performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- preif_ready_go  in  1  next-PC fetch request accepted; new instruction may enter IF
- if_ready_go  in  1  IF stage done
- id_ready_go  in  1  ID stage done; low on hazard interlock
- exe_ready_go  in  1  EXE stage done
- mem_ready_go  in  1  MEM stage done
- wb_ready_go  in  1  WB stage done
- exe_br_taken  in  1  EXE instruction is a taken branch or jump
- wb_ex  in  1  WB instruction raises an exception
- wb_is_ertn  in  1  WB instruction is ertn
- if_valid, id_valid, exe_valid, mem_valid, wb_valid  out  1 each  registered stage valid bits
- if_allowin, id_allowin, exe_allowin, mem_allowin, wb_allowin  out  1 each  combinational: stage may accept a new instruction
- if_load, id_load, exe_load, mem_load, wb_load  out  1 each  combinational capture enable for the stage's input register
- flush  out  1  combinational: pipeline-wide flush this cycle
- br_cancel  out  1  combinational: wrong-path squash this cycle
- retire_cnt  out  CNT_W  instructions retired, saturating
- bubble_cnt  out  CNT_W  cycles with no WB retirement, saturating

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset: all `*_valid` = 0, `retire_cnt` = 0, `bubble_cnt` = 0. While `rst` = 1, all `*_load`, `flush` and `br_cancel` are forced to 0.
- Reset mid-operation discards every in-flight instruction with no counter update.
- Fire signals, for stage s with successor n:
  - `s_fire = s_valid & s_ready_go & n_allowin`
  - `wb_fire = wb_valid & wb_ready_go`
- Allowin:
  - `wb_allowin = !wb_valid | wb_ready_go`
  - `s_allowin = !s_valid | (s_ready_go & n_allowin)`
  - An invalid stage always allows in, regardless of its ready_go.
- Flush and cancel:
  - `flush = wb_valid & (wb_ex | wb_is_ertn)`
  - `br_cancel = exe_valid & exe_ready_go & mem_allowin & exe_br_taken & !flush`
  - Precedence: flush > br_cancel > normal advance/stall.
- Load enables:
  - `if_load = if_allowin & preif_ready_go & !flush & !br_cancel`
  - `id_load = if_fire & !flush & !br_cancel`
  - `exe_load = id_fire & !flush & !br_cancel`
  - `mem_load = exe_fire & !flush`
  - `wb_load = mem_fire & !flush`
- Valid update, every posedge unless `rst`:
  - If `flush`: all five valids go to 0.
  - Else `if_valid` and `id_valid`: if `br_cancel`, go to 0. Otherwise, if the stage's allowin is 1, the valid takes the value of the stage's load.
  - Else `exe_valid`: if `exe_allowin` is 1, takes `exe_load`.
  - Else `mem_valid` and `wb_valid`: if the stage's allowin is 1, the valid takes the value of the stage's load.
  - A stage whose allowin is 0 holds its valid bit.
- Latency: with all ready_go = 1, an instruction accepted at edge k has `wb_valid` = 1 after edge k+4. Throughput is 1 per cycle.
- Retirement: `retire_cnt` += 1 when `wb_fire & !wb_ex`; ertn counts as retired, an excepting instruction does not.
- Bubbles: `bubble_cnt` += 1 on every non-reset cycle where no instruction retires.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Simultaneous `flush` and a stall anywhere: flush wins and clears stalled stages too.
- `flush` or `br_cancel` with `preif_ready_go` = 1: the entering instruction is dropped; `if_valid` = 0 next cycle.
- Inputs `exe_br_taken`, `wb_ex` and `wb_is_ertn` are ignored when their stage valid is 0.

Test Plan:
- Release reset with all ready_go = 1 and `preif_ready_go` = 1 -> `if_valid` = 1 after edge 1, `wb_valid` = 1 after edge 5; `retire_cnt` = 1, 2, 3… on consecutive cycles; `bubble_cnt` = 5 thereafter.
- Pipe full, `mem_ready_go` = 0 for 3 cycles -> `mem_allowin`, `exe_allowin`, `id_allowin`, `if_allowin` and all upstream loads are 0 for 3 cycles; `wb_valid` = 0 for 3 cycles; `bubble_cnt` increases by exactly 3; no instruction is lost or duplicated; order is preserved.
- `exe_br_taken` = 1 with EXE firing -> `br_cancel` = 1 for one cycle; next cycle `if_valid` = 0, `id_valid` = 0, `mem_valid` = 1 holding the branch; no wrong-path instruction reaches WB.
- `wb_ex` = 1 with `wb_valid` = 1 -> `flush` = 1, all loads 0; all valids 0 next cycle; `retire_cnt` unchanged. Repeat with `wb_is_ertn` -> `retire_cnt` += 1.
- Same cycle `wb_ex` = 1 and EXE taken branch firing -> `flush` = 1, `br_cancel` = 0, all valids 0.
- CNT_W = 4, 20 back-to-back retirements -> `retire_cnt` stops at 15. Then assert `rst` for 1 cycle with the pipe full -> all valids and both counters are 0 after that edge.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: valid bits, allowin/load handshakes, branch squash, exception flush
// and saturating retire/bubble counters for a five-stage pipeline.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             preif_ready_go,
  input  logic             if_ready_go,
  input  logic             id_ready_go,
  input  logic             exe_ready_go,
  input  logic             mem_ready_go,
  input  logic             wb_ready_go,
  input  logic             exe_br_taken,
  input  logic             wb_ex,
  input  logic             wb_is_ertn,
  output logic             if_valid,
  output logic             id_valid,
  output logic             exe_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic             if_allowin,
  output logic             id_allowin,
  output logic             exe_allowin,
  output logic             mem_allowin,
  output logic             wb_allowin,
  output logic             if_load,
  output logic             id_load,
  output logic             exe_load,
  output logic             mem_load,
  output logic             wb_load,
  output logic             flush,
  output logic             br_cancel,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);
  logic [4:0] valid_q, valid_d;
  logic [CNT_W-1:0] retire_q, retire_d, bubble_q, bubble_d;
  logic if_fire, id_fire, exe_fire, mem_fire, wb_fire, retire;
  always_comb begin
    wb_allowin  = !valid_q[4] | wb_ready_go;
    mem_allowin = !valid_q[3] | (mem_ready_go & wb_allowin);
    exe_allowin = !valid_q[2] | (exe_ready_go & mem_allowin);
    id_allowin  = !valid_q[1] | (id_ready_go & exe_allowin);
    if_allowin  = !valid_q[0] | (if_ready_go & id_allowin);
    if_fire  = valid_q[0] & if_ready_go & id_allowin;
    id_fire  = valid_q[1] & id_ready_go & exe_allowin;
    exe_fire = valid_q[2] & exe_ready_go & mem_allowin;
    mem_fire = valid_q[3] & mem_ready_go & wb_allowin;
    wb_fire  = valid_q[4] & wb_ready_go;
    flush     = !rst & valid_q[4] & (wb_ex | wb_is_ertn);
    br_cancel = !rst & exe_fire & exe_br_taken & !flush;
    if_load  = !rst & if_allowin & preif_ready_go & !flush & !br_cancel;
    id_load  = !rst & if_fire & !flush & !br_cancel;
    exe_load = !rst & id_fire & !flush & !br_cancel;
    mem_load = !rst & exe_fire & !flush;
    wb_load  = !rst & mem_fire & !flush;
    retire   = wb_fire & !wb_ex;
    // a taken branch leaves EXE for MEM, so only IF/ID need an explicit squash
    valid_d[0] = (flush | br_cancel) ? 1'b0 : if_allowin ? if_load : valid_q[0];
    valid_d[1] = (flush | br_cancel) ? 1'b0 : id_allowin ? id_load : valid_q[1];
    valid_d[2] = flush ? 1'b0 : exe_allowin ? exe_load : valid_q[2];
    valid_d[3] = flush ? 1'b0 : mem_allowin ? mem_load : valid_q[3];
    valid_d[4] = flush ? 1'b0 : wb_allowin ? wb_load : valid_q[4];
    retire_d = (retire & ~&retire_q) ? retire_q + CNT_W'(1) : retire_q;
    bubble_d = (!retire & ~&bubble_q) ? bubble_q + CNT_W'(1) : bubble_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      retire_q <= '0;
      bubble_q <= '0;
    end else begin
      valid_q  <= valid_d;
      retire_q <= retire_d;
      bubble_q <= bubble_d;
    end
  end
  assign if_valid   = valid_q[0];
  assign id_valid   = valid_q[1];
  assign exe_valid  = valid_q[2];
  assign mem_valid  = valid_q[3];
  assign wb_valid   = valid_q[4];
  assign retire_cnt = retire_q;
  assign bubble_cnt = bubble_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: randomized and directed checks of pipe_ctrl against an
// instruction-slot model of the pipeline (one ID per occupied stage).
module tb_pipe_ctrl;
  logic clk = 0, rst = 1, preif = 0, brt = 0, ex = 0, ertn = 0;
  logic [4:0] rg = '0;
  logic [4:0] v, al, ld, v4, al4, ld4;
  logic fl, bc, fl4, bc4;
  logic [31:0] ret, bub;
  logic [3:0] ret4, bub4;
  int total = 0, bad = 0;
  int occ[5], nocc[5];
  int next_id = 0;
  logic [4:0] m_v, m_lv, m_al, m_ld;
  logic m_fl, m_bc, m_rt;
  longint m_ret = 0, m_bub = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .preif_ready_go(preif),
    .if_ready_go(rg[0]), .id_ready_go(rg[1]), .exe_ready_go(rg[2]),
    .mem_ready_go(rg[3]), .wb_ready_go(rg[4]),
    .exe_br_taken(brt), .wb_ex(ex), .wb_is_ertn(ertn),
    .if_valid(v[0]), .id_valid(v[1]), .exe_valid(v[2]), .mem_valid(v[3]), .wb_valid(v[4]),
    .if_allowin(al[0]), .id_allowin(al[1]), .exe_allowin(al[2]), .mem_allowin(al[3]), .wb_allowin(al[4]),
    .if_load(ld[0]), .id_load(ld[1]), .exe_load(ld[2]), .mem_load(ld[3]), .wb_load(ld[4]),
    .flush(fl), .br_cancel(bc), .retire_cnt(ret), .bubble_cnt(bub)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .preif_ready_go(preif),
    .if_ready_go(rg[0]), .id_ready_go(rg[1]), .exe_ready_go(rg[2]),
    .mem_ready_go(rg[3]), .wb_ready_go(rg[4]),
    .exe_br_taken(brt), .wb_ex(ex), .wb_is_ertn(ertn),
    .if_valid(v4[0]), .id_valid(v4[1]), .exe_valid(v4[2]), .mem_valid(v4[3]), .wb_valid(v4[4]),
    .if_allowin(al4[0]), .id_allowin(al4[1]), .exe_allowin(al4[2]), .mem_allowin(al4[3]), .wb_allowin(al4[4]),
    .if_load(ld4[0]), .id_load(ld4[1]), .exe_load(ld4[2]), .mem_load(ld4[3]), .wb_load(ld4[4]),
    .flush(fl4), .br_cancel(bc4), .retire_cnt(ret4), .bubble_cnt(bub4)
  );

  // Instructions move toward WB when the slot ahead is empty or emptying; loads
  // are read off as "a different instruction occupies this slot next cycle".
  task automatic model_comb();
    int inc;
    for (int s = 0; s < 5; s++) m_v[s] = occ[s] >= 0;
    m_lv[4] = m_v[4] & rg[4];
    for (int s = 3; s >= 0; s--) m_lv[s] = m_v[s] & rg[s] & (!m_v[s+1] | m_lv[s+1]);
    m_al = ~m_v | m_lv;
    m_fl = !rst & m_v[4] & (ex | ertn);
    m_bc = !rst & m_lv[2] & brt & !m_fl;
    m_rt = !rst & m_lv[4] & !ex;
    for (int s = 0; s < 5; s++) begin
      if (s == 0) inc = (m_al[0] & preif) ? next_id : -1;
      else inc = m_lv[s-1] ? occ[s-1] : -1;
      nocc[s] = inc >= 0 ? inc : (m_lv[s] ? -1 : occ[s]);
      if (rst || m_fl || (m_bc && s < 3)) nocc[s] = -1;
      m_ld[s] = nocc[s] >= 0 && nocc[s] != occ[s];
    end
  endtask

  task automatic model_adv();
    if (rst) begin
      m_ret = 0;
      m_bub = 0;
    end else if (m_rt) m_ret++;
    else m_bub++;
    if (nocc[0] == next_id) next_id++;
    for (int s = 0; s < 5; s++) occ[s] = nocc[s];
  endtask

  task automatic eval();
    #1;
    model_comb();
  endtask

  task automatic adv();
    model_adv();
    @(negedge clk);
  endtask

  task automatic refill();
    rg = '1; preif = 1; brt = 0; ex = 0; ertn = 0;
    for (int i = 0; i < 6; i++) begin
      eval();
      total++; if (v !== m_v) begin bad++; $display("FAIL refill_valid got=%b exp=%b", v, m_v); end
      adv();
    end
  endtask

  task automatic test_reset();
    rst = 1; rg = '1; preif = 1; ex = 1; brt = 1;
    eval(); adv(); eval();
    total++; if (v !== 5'b0) begin bad++; $display("FAIL reset_valid got=%b exp=00000", v); end
    total++; if (ld !== 5'b0) begin bad++; $display("FAIL reset_load got=%b exp=00000", ld); end
    total++; if ({fl, bc} !== 2'b00) begin bad++; $display("FAIL reset_flush_cancel got=%b exp=00", {fl, bc}); end
    total++; if (ret !== 0 || bub !== 0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", ret, bub); end
    total++; if (v4 !== 5'b0 || ret4 !== 0) begin bad++; $display("FAIL reset_dut4 got=%b/%0d exp=0", v4, ret4); end
    adv();
    ex = 0; brt = 0;
  endtask

  task automatic test_fill();
    rst = 0; rg = '1; preif = 1;
    for (int k = 0; k < 12; k++) begin
      eval();
      total++; if (v[0] !== 1'(k >= 1)) begin bad++; $display("FAIL fill_if_valid k=%0d got=%b exp=%b", k, v[0], k >= 1); end
      total++; if (v[4] !== 1'(k >= 5)) begin bad++; $display("FAIL fill_wb_valid k=%0d got=%b exp=%b", k, v[4], k >= 5); end
      total++; if (ret !== 32'(k > 5 ? k - 5 : 0)) begin bad++; $display("FAIL fill_retire k=%0d got=%0d", k, ret); end
      total++; if (bub !== 32'(k < 5 ? k : 5)) begin bad++; $display("FAIL fill_bubble k=%0d got=%0d", k, bub); end
      total++; if (ld !== m_ld) begin bad++; $display("FAIL fill_load k=%0d got=%b exp=%b", k, ld, m_ld); end
      adv();
    end
  endtask

  task automatic test_mem_stall();
    longint b0 = m_bub;
    rg[3] = 0;
    for (int i = 0; i < 3; i++) begin
      eval();
      total++; if (al[3:0] !== 4'b0) begin bad++; $display("FAIL stall_allowin i=%0d got=%b exp=0000", i, al[3:0]); end
      total++; if (ld !== 5'b0) begin bad++; $display("FAIL stall_load i=%0d got=%b exp=00000", i, ld); end
      total++; if (v !== m_v) begin bad++; $display("FAIL stall_valid i=%0d got=%b exp=%b", i, v, m_v); end
      if (i > 0) begin
        total++; if (v[4] !== 1'b0) begin bad++; $display("FAIL stall_wb_valid i=%0d got=%b exp=0", i, v[4]); end
      end
      adv();
    end
    rg[3] = 1;
    for (int i = 0; i < 4; i++) begin
      eval();
      total++; if (v !== m_v) begin bad++; $display("FAIL stall_rel_valid i=%0d got=%b exp=%b", i, v, m_v); end
      adv();
    end
    eval();
    total++; if (bub !== 32'(b0 + 3)) begin bad++; $display("FAIL stall_bubble got=%0d exp=%0d", bub, b0 + 3); end
    total++; if (ret !== m_ret[31:0]) begin bad++; $display("FAIL stall_retire got=%0d exp=%0d", ret, m_ret); end
    adv();
  endtask

  task automatic test_branch();
    refill();
    brt = 1;
    eval();
    total++; if ({fl, bc} !== 2'b01) begin bad++; $display("FAIL br_cancel got=%b exp=01", {fl, bc}); end
    total++; if (ld !== 5'b11000) begin bad++; $display("FAIL br_load got=%b exp=11000", ld); end
    adv();
    brt = 0;
    eval();
    total++; if (v !== 5'b11000) begin bad++; $display("FAIL br_valid got=%b exp=11000", v); end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) eval();
      total++; if (ret !== m_ret[31:0]) begin bad++; $display("FAIL br_retire i=%0d got=%0d exp=%0d", i, ret, m_ret); end
      adv();
    end
  endtask

  task automatic test_flush();
    longint r0;
    refill();
    ex = 1;
    eval();
    total++; if ({fl, bc} !== 2'b10) begin bad++; $display("FAIL ex_flush got=%b exp=10", {fl, bc}); end
    total++; if (ld !== 5'b0) begin bad++; $display("FAIL ex_load got=%b exp=00000", ld); end
    r0 = m_ret;
    adv();
    ex = 0;
    eval();
    total++; if (v !== 5'b0) begin bad++; $display("FAIL ex_valid got=%b exp=00000", v); end
    total++; if (ret !== 32'(r0)) begin bad++; $display("FAIL ex_retire got=%0d exp=%0d", ret, r0); end
    adv();
    refill();
    ertn = 1;
    eval();
    total++; if (fl !== 1'b1) begin bad++; $display("FAIL ertn_flush got=%b exp=1", fl); end
    r0 = m_ret;
    adv();
    ertn = 0;
    eval();
    total++; if (v !== 5'b0) begin bad++; $display("FAIL ertn_valid got=%b exp=00000", v); end
    total++; if (ret !== 32'(r0 + 1)) begin bad++; $display("FAIL ertn_retire got=%0d exp=%0d", ret, r0 + 1); end
    adv();
  endtask

  task automatic test_flush_vs_branch();
    refill();
    ex = 1; brt = 1;
    eval();
    total++; if ({fl, bc} !== 2'b10) begin bad++; $display("FAIL fxb_flags got=%b exp=10", {fl, bc}); end
    adv();
    ex = 0; brt = 0;
    eval();
    total++; if (v !== 5'b0) begin bad++; $display("FAIL fxb_valid got=%b exp=00000", v); end
    adv();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom % 64) == 0;
      for (int s = 0; s < 5; s++) rg[s] = ($urandom % 4) != 0;
      preif = ($urandom % 4) != 0;
      brt = ($urandom % 8) == 0;
      ex = ($urandom % 16) == 0;
      ertn = ($urandom % 16) == 0;
      eval();
      total++; if (v !== m_v) begin bad++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, v, m_v); end
      total++; if (al !== m_al) begin bad++; $display("FAIL rnd_allowin i=%0d got=%b exp=%b", i, al, m_al); end
      total++; if (ld !== m_ld) begin bad++; $display("FAIL rnd_load i=%0d got=%b exp=%b", i, ld, m_ld); end
      total++; if (fl !== m_fl) begin bad++; $display("FAIL rnd_flush i=%0d got=%b exp=%b", i, fl, m_fl); end
      total++; if (bc !== m_bc) begin bad++; $display("FAIL rnd_br_cancel i=%0d got=%b exp=%b", i, bc, m_bc); end
      total++; if (ret !== m_ret[31:0]) begin bad++; $display("FAIL rnd_retire i=%0d got=%0d exp=%0d", i, ret, m_ret); end
      total++; if (bub !== m_bub[31:0]) begin bad++; $display("FAIL rnd_bubble i=%0d got=%0d exp=%0d", i, bub, m_bub); end
      total++; if (ret4 !== 4'(m_ret > 15 ? 15 : m_ret) || bub4 !== 4'(m_bub > 15 ? 15 : m_bub)) begin
        bad++; $display("FAIL rnd_cnt4 i=%0d got=%0d/%0d exp=%0d/%0d", i, ret4, bub4, m_ret, m_bub);
      end
      total++; if ({v4, al4, ld4, fl4, bc4} !== {m_v, m_al, m_ld, m_fl, m_bc}) begin
        bad++; $display("FAIL rnd_dut4_ctrl i=%0d got=%b/%b/%b", i, v4, al4, ld4);
      end
      adv();
    end
    rst = 0; brt = 0; ex = 0; ertn = 0;
  endtask

  task automatic test_saturate();
    rst = 1; rg = '1; preif = 1; brt = 0; ex = 0; ertn = 0;
    eval(); adv();
    rst = 0;
    for (int i = 0; i < 25; i++) begin eval(); adv(); end
    eval();
    total++; if (ret4 !== 4'd15) begin bad++; $display("FAIL sat_retire4 got=%0d exp=15", ret4); end
    total++; if (ret !== 32'd20) begin bad++; $display("FAIL sat_retire32 got=%0d exp=20", ret); end
    total++; if (bub4 !== 4'd5) begin bad++; $display("FAIL sat_bubble4 got=%0d exp=5", bub4); end
    rst = 1;
    eval();
    total++; if (ld !== 5'b0 || fl !== 1'b0) begin bad++; $display("FAIL rst_full_load got=%b/%b exp=0", ld, fl); end
    adv();
    eval();
    total++; if (v !== 5'b0 || v4 !== 5'b0) begin bad++; $display("FAIL rst_full_valid got=%b/%b exp=0", v, v4); end
    total++; if (ret !== 0 || bub !== 0 || ret4 !== 0 || bub4 !== 0) begin
      bad++; $display("FAIL rst_full_cnt got=%0d/%0d/%0d/%0d exp=0", ret, bub, ret4, bub4);
    end
    adv();
    rst = 0;
  endtask

  initial begin
    for (int s = 0; s < 5; s++) occ[s] = -1;
    test_reset();
    test_fill();
    test_mem_stall();
    test_branch();
    test_flush();
    test_flush_vs_branch();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
